// File: rtl/bsg_manycore_io_router_sdr_link_test_ctrl.sv
// Sequences one SDR link test node: hold in reset, send a fixed packet count, drain returns, report result.
// Define BSG_SDR_LINK_TEST_TIMEOUT_EN to build the receive-stall watchdog (fail code 2).
module bsg_manycore_io_router_sdr_link_test_ctrl #(
   parameter int num_pkts_width_p = 16,
   parameter int timeout_width_p  = 16,
   parameter int clear_cycles_p   = 4
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        start_i,
   input  logic [num_pkts_width_p-1:0] num_pkts_i,
   input  logic [timeout_width_p-1:0]  timeout_i,
   input  logic                        node_error_i,
   input  logic [31:0]                 node_sent_i,
   input  logic [31:0]                 node_received_i,
   output logic                        node_reset_o,
   output logic                        node_en_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        pass_o,
   output logic [1:0]                  fail_code_o,
   output logic [31:0]                 cycles_o
);

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_e;

   localparam int clr_width_lp = $clog2(clear_cycles_p);
   localparam logic [clr_width_lp-1:0] clr_last_lp = clr_width_lp'(clear_cycles_p - 1);

   state_e                      state_r;
   logic [num_pkts_width_p-1:0] target_r;
   logic [31:0]                 target_ext;
   logic [clr_width_lp-1:0]     clr_cnt_r;
   logic                        overrun;
   logic                        timeout_hit;

   assign target_ext = 32'(target_r);
   assign overrun    = (node_received_i > node_sent_i);

   // Combinational so the node sees en drop in the same cycle sent reaches the target.
   assign node_en_o = (state_r == RUN) && (node_sent_i < target_ext);

`ifdef BSG_SDR_LINK_TEST_TIMEOUT_EN
   logic [timeout_width_p-1:0] limit_r;
   logic [timeout_width_p-1:0] wd_r;
   logic [31:0]                prev_rx_r;

   assign timeout_hit = (wd_r >= limit_r);
`else
   logic unused_timeout;
   assign unused_timeout = ^timeout_i;
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r      <= IDLE;
         target_r     <= '0;
         clr_cnt_r    <= '0;
         node_reset_o <= 1'b1;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         pass_o       <= 1'b0;
         fail_code_o  <= 2'd0;
         cycles_o     <= '0;
`ifdef BSG_SDR_LINK_TEST_TIMEOUT_EN
         limit_r      <= '0;
         wd_r         <= '0;
         prev_rx_r    <= '0;
`endif
      end else begin
`ifdef BSG_SDR_LINK_TEST_TIMEOUT_EN
         prev_rx_r <= node_received_i;
`endif
         case (state_r)
            IDLE, DONE: begin
               if (start_i) begin
                  state_r      <= CLEAR;
                  target_r     <= num_pkts_i;
                  clr_cnt_r    <= '0;
                  node_reset_o <= 1'b1;
                  busy_o       <= 1'b1;
                  done_o       <= 1'b0;
                  pass_o       <= 1'b0;
                  fail_code_o  <= 2'd0;
                  cycles_o     <= '0;
`ifdef BSG_SDR_LINK_TEST_TIMEOUT_EN
                  limit_r      <= timeout_i;
                  wd_r         <= '0;
`endif
               end
            end

            CLEAR: begin
               cycles_o    <= '0;
               fail_code_o <= 2'd0;
`ifdef BSG_SDR_LINK_TEST_TIMEOUT_EN
               wd_r        <= '0;
`endif
               if (clr_cnt_r == clr_last_lp) begin
                  state_r      <= RUN;
                  node_reset_o <= 1'b0;
               end else begin
                  clr_cnt_r <= clr_cnt_r + 1'b1;
               end
            end

            RUN, DRAIN: begin
               if (cycles_o != '1)
                  cycles_o <= cycles_o + 32'd1;
`ifdef BSG_SDR_LINK_TEST_TIMEOUT_EN
               wd_r <= (node_received_i != prev_rx_r) ? '0 : wd_r + 1'b1;
`endif
               // Failures outrank normal progress; data error > overrun > timeout.
               if (node_error_i || overrun || timeout_hit) begin
                  state_r     <= DONE;
                  busy_o      <= 1'b0;
                  done_o      <= 1'b1;
                  pass_o      <= 1'b0;
                  fail_code_o <= node_error_i ? 2'd1 : (overrun ? 2'd3 : 2'd2);
               end else if (state_r == RUN) begin
                  if (node_sent_i == target_ext)
                     state_r <= DRAIN;
               end else if (node_received_i == node_sent_i) begin
                  state_r     <= DONE;
                  busy_o      <= 1'b0;
                  done_o      <= 1'b1;
                  pass_o      <= 1'b1;
                  fail_code_o <= 2'd0;
               end
            end

            default: state_r <= IDLE;
         endcase
      end
   end

endmodule
